piso_serialiser: RTL and testbench

- Parametrised parallel-in/serial-out shifter for the I2C slave transmit path.
- Accepts a WIDTH-bit word through a valid/ready handshake, then presents it one bit per shift_i strobe on data_o.
- shift_i is typically the SCL-falling-edge strobe from the bus front end.
- Supports configurable bit order and idle level, reports completion, and can be aborted by bus events such as STOP or arbitration loss.

---
 rtl/piso_serialiser_if.sv | 36 +++
 rtl/piso_serialiser.sv | 121 ++++++++++++
 tb/tb_piso_serialiser.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_serialiser_if.sv
// Handshake/serial bundle for piso_serialiser.
// PISO_ACK_CAPTURE_EN adds sda_i/nack_o for the ACK slot.
interface piso_serialiser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             load_i;
    logic             ready_o;
    logic             shift_i;
    logic             abort_i;
    logic             data_o;
    logic             busy_o;
    logic             done_o;
`ifdef PISO_ACK_CAPTURE_EN
    logic             sda_i;
    logic             nack_o;
`endif

    modport master (
        output data_i, load_i, shift_i, abort_i,
`ifdef PISO_ACK_CAPTURE_EN
        output sda_i,
        input  nack_o,
`endif
        input  ready_o, data_o, busy_o, done_o
    );

    modport slave (
        input  data_i, load_i, shift_i, abort_i,
`ifdef PISO_ACK_CAPTURE_EN
        input  sda_i,
        output nack_o,
`endif
        output ready_o, data_o, busy_o, done_o
    );
endinterface

// File: rtl/piso_serialiser.sv
// Parallel-in/serial-out shifter for the I2C slave transmit path.
// Optional ACK-slot capture of sda_i into nack_o under PISO_ACK_CAPTURE_EN.
module piso_serialiser #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int IDLE_LEVEL = 1
) (
    input  logic               clk_i,
    input  logic               rst_n,
    piso_serialiser_if.slave   bus
);
    localparam int   CW       = $clog2(WIDTH);
    localparam logic IDLE_BIT = IDLE_LEVEL[0];

`ifdef PISO_ACK_CAPTURE_EN
    typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             data_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
`ifdef PISO_ACK_CAPTURE_EN
    logic             nack_q;
`endif

    // Every output is registered so data_o never glitches onto SDA.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            data_q  <= IDLE_BIT;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_ACK_CAPTURE_EN
            nack_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_i) begin
                        sreg    <= bus.data_i;
                        cnt     <= CW'(WIDTH - 1);
                        data_q  <= (MSB_FIRST != 0) ? bus.data_i[WIDTH-1] : bus.data_i[0];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
`ifdef PISO_ACK_CAPTURE_EN
                        nack_q  <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (bus.abort_i) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        data_q  <= IDLE_BIT;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (bus.shift_i) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                            if (MSB_FIRST != 0) begin
                                sreg   <= {sreg[WIDTH-2:0], 1'b0};
                                data_q <= sreg[WIDTH-2];
                            end else begin
                                sreg   <= {1'b0, sreg[WIDTH-1:1]};
                                data_q <= sreg[1];
                            end
                        end else begin
                            data_q <= IDLE_BIT;
`ifdef PISO_ACK_CAPTURE_EN
                            // SDA released so the master can drive ACK/NACK.
                            state   <= ACK;
`else
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef PISO_ACK_CAPTURE_EN
                ACK: begin
                    if (bus.abort_i) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        data_q  <= IDLE_BIT;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (bus.shift_i) begin
                        nack_q  <= bus.sda_i;
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_o  = data_q;
    assign bus.ready_o = ready_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
`ifdef PISO_ACK_CAPTURE_EN
    assign bus.nack_o  = nack_q;
`endif
endmodule

// File: tb/tb_piso_serialiser.sv
// Scoreboard bench: three instances (8 MSB-first, 8 LSB-first, 16 MSB-first).
module tb_piso_serialiser;
    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

`ifdef PISO_ACK_CAPTURE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic [2:0]  load = '0, shift = '0, abrt = '0, sda = '0;
    logic [15:0] din [3];
    logic [2:0]  dout, done, busy, ready, nack;

    piso_serialiser_if #(.WIDTH(8))  bm8 ();
    piso_serialiser_if #(.WIDTH(8))  bl8 ();
    piso_serialiser_if #(.WIDTH(16)) b16 ();

    piso_serialiser #(.WIDTH(8),  .MSB_FIRST(1), .IDLE_LEVEL(1)) u_m8  (.clk_i(clk_i), .rst_n(rst_n), .bus(bm8));
    piso_serialiser #(.WIDTH(8),  .MSB_FIRST(0), .IDLE_LEVEL(1)) u_l8  (.clk_i(clk_i), .rst_n(rst_n), .bus(bl8));
    piso_serialiser #(.WIDTH(16), .MSB_FIRST(1), .IDLE_LEVEL(1)) u_w16 (.clk_i(clk_i), .rst_n(rst_n), .bus(b16));

    assign bm8.data_i = din[0][7:0];
    assign bl8.data_i = din[1][7:0];
    assign b16.data_i = din[2];
    assign {b16.load_i,  bl8.load_i,  bm8.load_i}  = load;
    assign {b16.shift_i, bl8.shift_i, bm8.shift_i} = shift;
    assign {b16.abort_i, bl8.abort_i, bm8.abort_i} = abrt;
    assign dout  = {b16.data_o,  bl8.data_o,  bm8.data_o};
    assign done  = {b16.done_o,  bl8.done_o,  bm8.done_o};
    assign busy  = {b16.busy_o,  bl8.busy_o,  bm8.busy_o};
    assign ready = {b16.ready_o, bl8.ready_o, bm8.ready_o};
`ifdef PISO_ACK_CAPTURE_EN
    assign {b16.sda_i, bl8.sda_i, bm8.sda_i} = sda;
    assign nack = {b16.nack_o, bl8.nack_o, bm8.nack_o};
`else
    assign nack = '0;
`endif

    // Expected {data_o, done_o, busy_o, ready_o} after each driven event.
    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] v;
    } exp_t;
    exp_t       sbq[$];
    logic [3:0] last_v [3];
    int checks = 0, failures = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [3:0] obs(int i);
        return {dout[i], done[i], busy[i], ready[i]};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_e(int i, logic [3:0] v);
        exp_t e;
        e.idx = i[1:0];
        e.v   = v;
        sbq.push_back(e);
    endtask

    // Whole transfer predicted at load time: first bit, then one entry per strobe.
    task automatic push_xfer(int i, logic [15:0] word);
        int w;
        logic b;
        w = (i == 2) ? 16 : 8;
        for (int k = 0; k < w; k++) begin
            b = (i != 1) ? word[w-1-k] : word[k];
            push_e(i, {b, 1'b0, 1'b1, 1'b0});
        end
        if (EXTRA != 0) push_e(i, 4'b1010);
        push_e(i, 4'b1101);
    endtask

    task automatic pop_chk(string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            last_v[e.idx] = e.v;
            chk(tag, 32'(obs(e.idx)), 32'(e.v));
        end
    endtask

    task automatic hold(int i, int n, string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            last_v[i][2] = 1'b0;
            chk(tag, 32'(obs(i)), 32'(last_v[i]));
        end
    endtask

    task automatic load_word(int i, logic [15:0] word, string tag);
        push_xfer(i, word);
        din[i]  = word;
        load[i] = 1'b1;
        tick();
        load[i] = 1'b0;
        pop_chk(tag);
    endtask

    task automatic strobe(int i, logic s, string tag);
        sda[i]   = s;
        shift[i] = 1'b1;
        tick();
        shift[i] = 1'b0;
        pop_chk(tag);
    endtask

    task automatic run_strobes(int i, int n, int gap, string tag);
        for (int k = 0; k < n; k++) begin
            strobe(i, 1'b0, tag);
            hold(i, gap, {tag, "_hold"});
        end
    endtask

    task automatic chk_reset_vals(string tag);
        for (int i = 0; i < 3; i++) begin
            chk(tag, 32'(obs(i)), 32'(4'b1001));
            chk({tag, "_nack"}, 32'(nack[i]), 0);
            last_v[i] = 4'b1001;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            din[i]    = '0;
            last_v[i] = 4'b1001;
        end
        repeat (2) tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // MSB-first 0xA5, strobes three cycles apart
        load_word(0, 16'h00A5, "a5_first");
        run_strobes(0, 8 + EXTRA, 2, "a5");

        // LSB-first 0x01, back-to-back strobes
        load_word(1, 16'h0001, "lsb_first");
        run_strobes(1, 8 + EXTRA, 0, "lsb");

        // 16-bit word exercises the full counter range
        load_word(2, 16'h8001, "w16_first");
        run_strobes(2, 16 + EXTRA, 1, "w16");

        // load while busy is ignored, then abort with a coincident shift
        load_word(0, 16'h0096, "mid_first");
        run_strobes(0, 3, 0, "mid");
        din[0]  = 16'h00FF;
        load[0] = 1'b1;
        hold(0, 1, "ld_busy");
        load[0] = 1'b0;
        run_strobes(0, 2, 0, "mid_cont");
        abrt[0]  = 1'b1;
        shift[0] = 1'b1;
        tick();
        abrt[0]  = 1'b0;
        shift[0] = 1'b0;
        sbq.delete();
        last_v[0] = 4'b1001;
        chk("abort", 32'(obs(0)), 32'(4'b1001));
        hold(0, 2, "abort_hold");

        // back-to-back load in the done_o cycle, then async reset mid-word
        load_word(0, 16'h00C3, "c3_first");
        run_strobes(0, 8 + EXTRA, 0, "c3");
        load_word(0, 16'h003C, "b2b_first");
        run_strobes(0, 3, 0, "b2b");
        #2 rst_n = 1'b0;
        #1;
        sbq.delete();
        chk_reset_vals("rst_mid");
        tick();
        rst_n = 1'b1;
        hold(0, 2, "post_rst");

`ifdef PISO_ACK_CAPTURE_EN
        load_word(0, 16'h0055, "ack1_first");
        run_strobes(0, 8, 0, "ack1");
        strobe(0, 1'b1, "ack1_slot");
        chk("nack_set", 32'(nack[0]), 1);
        hold(0, 2, "ack1_hold");
        chk("nack_holds", 32'(nack[0]), 1);
        load_word(0, 16'h0055, "ack0_first");
        chk("nack_clr_on_load", 32'(nack[0]), 0);
        run_strobes(0, 8, 0, "ack0");
        strobe(0, 1'b0, "ack0_slot");
        chk("nack_clr", 32'(nack[0]), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
